dbus_responder: RTL and testbench



---
 rtl/dbus_responder.sv | 139 +++++++++++++
 tb/tb_dbus_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// Data-bus responder: word-addressed 64-bit RAM behind a valid/data_ok handshake.
// Each request is answered after LATENCY cycles, stretched by one cycle per held WAIT cycle.
module dbus_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid_i,
  input  logic [63:0] dreq_addr_i,
  input  logic [2:0]  dreq_size_i,
  input  logic [7:0]  dreq_strobe_i,
  input  logic [63:0] dreq_data_i,
  input  logic        hold_i,
  output logic        dresp_addr_ok_o,
  output logic        dresp_data_ok_o,
  output logic [63:0] dresp_data_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [63:0] SpanBytes = 64'(DEPTH) << 3;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;

  logic [63:0] req_addr_q;
  logic [7:0]  req_strobe_q;
  logic [63:0] req_data_q;
  logic        req_write_q;

  logic        addr_ok_q, data_ok_q, err_q;
  logic [63:0] data_q;
  logic        resp_d, err_d;
  logic [63:0] data_d;

  logic [63:0]     mem [DEPTH];
  logic [63:0]     eff_addr, off;
  logic            in_range;
  logic [IdxW-1:0] idx;

  // size is informational only; off is only partly used for indexing
  logic unused_bits;
  assign unused_bits = ^{dreq_size_i, off};

  // In IDLE the live request is decoded so a LATENCY==1 response can read the RAM at once
  always_comb begin
    eff_addr = (state_q == StIdle) ? dreq_addr_i : req_addr_q;
    off      = eff_addr - BASE_ADDR;
    in_range = (eff_addr >= BASE_ADDR) && (off < SpanBytes);
    idx      = off[3 +: IdxW];
  end

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (dreq_valid_i) begin
          load    = 1'b1;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (!hold_i) begin
          if (cnt_q == CntOne) state_d = StResp;
          else                 cnt_d   = cnt_q - CntOne;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response is registered on entry to RESP so data, err and data_ok move together
  always_comb begin
    resp_d = (state_d == StResp);
    data_d = (resp_d && in_range) ? mem[idx] : 64'h0;
    err_d  = resp_d && !in_range;
  end

  // State, request register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      req_strobe_q <= '0;
      req_data_q   <= '0;
      req_write_q  <= 1'b0;
      addr_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_ok_q <= resp_d;
      data_ok_q <= resp_d;
      data_q    <= data_d;
      err_q     <= err_d;
      if (load) begin
        req_addr_q   <= dreq_addr_i;
        req_strobe_q <= dreq_strobe_i;
        req_data_q   <= dreq_data_i;
        req_write_q  <= |dreq_strobe_i;
      end
    end
  end

  // Byte-merge write on the edge leaving RESP; an async reset leaves RESP and drops it
  always_ff @(posedge clk) begin
    if (state_q == StResp && req_write_q && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (req_strobe_q[i]) mem[idx][8*i +: 8] <= req_data_q[8*i +: 8];
      end
    end
  end

  assign dresp_addr_ok_o = addr_ok_q;
  assign dresp_data_ok_o = data_ok_q;
  assign dresp_data_o    = data_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid0, valid1;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] data;
  logic        hold;

  logic        aok0, dok0, err0, busy0;
  logic [63:0] rdata0;
  logic        aok1, dok1, err1, busy1;
  logic [63:0] rdata1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dbus_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .dreq_valid_i(valid0), .dreq_addr_i(addr), .dreq_size_i(size),
    .dreq_strobe_i(strobe), .dreq_data_i(data), .hold_i(hold),
    .dresp_addr_ok_o(aok0), .dresp_data_ok_o(dok0), .dresp_data_o(rdata0),
    .err_o(err0), .busy_o(busy0)
  );

  dbus_responder #(.DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .dreq_valid_i(valid1), .dreq_addr_i(addr), .dreq_size_i(size),
    .dreq_strobe_i(strobe), .dreq_data_i(data), .hold_i(hold),
    .dresp_addr_ok_o(aok1), .dresp_data_ok_o(dok1), .dresp_data_o(rdata1),
    .err_o(err1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request from cycle 0; hold high for cycles [hs, hs+hl). Returns the data_ok cycle.
  task automatic txn(input int sel, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] d, input int hs, input int hl,
                     output int lat, output logic [63:0] rd, output logic re,
                     output logic ra, output int bc);
    addr   = a;
    strobe = s;
    data   = d;
    size   = 3'd3;
    if (sel == 0) valid0 = 1'b1;
    else          valid1 = 1'b1;
    lat = -1;
    rd  = '0;
    re  = 1'b0;
    ra  = 1'b0;
    bc  = 0;
    for (int c = 0; c < 30; c++) begin
      hold = (c >= hs) && (c < hs + hl);
      @(negedge clk);
      if ((sel == 0) ? busy0 : busy1) bc++;
      if ((sel == 0) ? dok0 : dok1) begin
        lat = c;
        rd  = (sel == 0) ? rdata0 : rdata1;
        re  = (sel == 0) ? err0 : err1;
        ra  = (sel == 0) ? aok0 : aok1;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
    hold   = 1'b0;
  endtask

  // Cycle after the response: data_ok gone, back to idle
  task automatic post(input int sel, input string tag);
    @(negedge clk);
    chk({tag, "_dok_low"}, 64'((sel == 0) ? dok0 : dok1), 64'd0);
    chk({tag, "_idle"}, 64'((sel == 0) ? busy0 : busy1), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, bc;
    logic [63:0] rd;
    logic        re, ra;
    bit          seen;

    reset = 1'b0; valid0 = 1'b0; valid1 = 1'b0; hold = 1'b0;
    addr = '0; size = '0; strobe = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dok", 64'(dok0), 64'd0);
    chk("rst_aok", 64'(aok0), 64'd0);
    chk("rst_data", rdata0, 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_dok1", 64'(dok1), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // T1 full-word write then read
    txn(0, 64'h8000_0010, 8'hff, 64'h1122334455667788, 99, 0, lat, rd, re, ra, bc);
    chk("t1_wr_lat", 64'(lat), 64'd2);
    chk("t1_wr_aok", 64'(ra), 64'd1);
    chk("t1_wr_err", 64'(re), 64'd0);
    chk("t1_wr_busy", 64'(bc), 64'd2);
    post(0, "t1_wr");
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t1_rd_lat", 64'(lat), 64'd2);
    chk("t1_rd_data", rd, 64'h1122334455667788);
    chk("t1_rd_err", 64'(re), 64'd0);
    post(0, "t1_rd");

    // T2 strobed merges; addr[2:0] ignored for indexing
    txn(0, 64'h8000_0020, 8'hff, 64'h0, 99, 0, lat, rd, re, ra, bc);
    txn(0, 64'h8000_0024, 8'hf0, 64'hAABBCCDD_00000000, 99, 0, lat, rd, re, ra, bc);
    txn(0, 64'h8000_0020, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t2_rd1", rd, 64'hAABBCCDD_00000000);
    txn(0, 64'h8000_0020, 8'h01, 64'h00000000_000000EE, 99, 0, lat, rd, re, ra, bc);
    chk("t2_prewrite", rd, 64'hAABBCCDD_00000000);
    txn(0, 64'h8000_0020, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t2_rd2", rd, 64'hAABBCCDD_000000EE);

    // T3 three held WAIT cycles
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 1, 3, lat, rd, re, ra, bc);
    chk("t3_lat", 64'(lat), 64'd5);
    chk("t3_busy", 64'(bc), 64'd5);
    chk("t3_data", rd, 64'h1122334455667788);
    post(0, "t3");

    // T4 out-of-range accesses
    txn(0, 64'h8000_1FF8, 8'hff, 64'h5A5A5A5A_A5A5A5A5, 99, 0, lat, rd, re, ra, bc);
    chk("t4_last_err", 64'(re), 64'd0);
    txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t4_lo_err", 64'(re), 64'd1);
    chk("t4_lo_data", rd, 64'd0);
    chk("t4_lo_lat", 64'(lat), 64'd2);
    txn(0, 64'h8000_2000, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t4_hi_err", 64'(re), 64'd1);
    chk("t4_hi_data", rd, 64'd0);
    txn(0, 64'h8000_2000, 8'hff, 64'hFFFFFFFF_FFFFFFFF, 99, 0, lat, rd, re, ra, bc);
    chk("t4_hiwr_err", 64'(re), 64'd1);
    chk("t4_hiwr_aok", 64'(ra), 64'd1);
    txn(0, 64'h8000_1FF8, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t4_last_kept", rd, 64'h5A5A5A5A_A5A5A5A5);
    chk("t4_last_rd_err", 64'(re), 64'd0);

    // T5 reset in the WAIT cycle of a write
    addr = 64'h8000_0010; strobe = 8'hff; data = 64'hDEADBEEF_0BADF00D; valid0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_wait_busy", 64'(busy0), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_busy", 64'(busy0), 64'd0);
    chk("t5_dok", 64'(dok0), 64'd0);
    chk("t5_data", rdata0, 64'd0);
    valid0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dok0) seen = 1'b1;
    end
    chk("t5_no_dok", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    txn(0, 64'h8000_0010, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t5_old_word", rd, 64'h1122334455667788);

    // T6 back-to-back: second request raised the cycle after data_ok
    txn(0, 64'h8000_0030, 8'hff, 64'h01234567_89ABCDEF, 99, 0, lat, rd, re, ra, bc);
    chk("t6_first_lat", 64'(lat), 64'd2);
    txn(0, 64'h8000_0030, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t6_second_lat", 64'(lat), 64'd2);
    chk("t6_second_data", rd, 64'h01234567_89ABCDEF);
    post(0, "t6");

    // T6 LATENCY=1 variant
    txn(1, 64'h8000_0040, 8'hff, 64'hCAFEF00D_12345678, 99, 0, lat, rd, re, ra, bc);
    chk("t6l1_wr_lat", 64'(lat), 64'd1);
    chk("t6l1_wr_busy", 64'(bc), 64'd1);
    txn(1, 64'h8000_0040, 8'h00, 64'h0, 99, 0, lat, rd, re, ra, bc);
    chk("t6l1_rd_lat", 64'(lat), 64'd1);
    chk("t6l1_rd_data", rd, 64'hCAFEF00D_12345678);
    post(1, "t6l1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
